reduce_sum_seq: RTL and testbench

- Sequential, area-reduced counterpart of the combinational reduce-sum datapath. It computes s = a + popcount(b) mod 2^A_size using a single shared incrementor step.
- The step is applied serially, one bit of b per clock, under an FSM.
- Operands enter through a valid/ready handshake, the result leaves through a valid/ready handshake, and overflow is flagged.
- Used where the B_size-deep incrementor chain is too large or too slow for one cycle.

---
 rtl/reduce_sum_seq_if.sv | 27 ++
 rtl/reduce_sum_seq.sv | 97 +++++++++
 tb/tb_reduce_sum_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reduce_sum_seq_if.sv
// Operand/result handshake bundle for reduce_sum_seq.
// master drives operands and consumes results; slave is the datapath.
interface reduce_sum_seq_if #(
  parameter int A_size = 8,
  parameter int B_size = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [A_size-1:0] a;
  logic [B_size-1:0] b;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [A_size-1:0] s;
  logic              ovf;
  logic              busy;

  modport master (
    output in_valid, a, b, abort, out_ready,
    input  in_ready, out_valid, s, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, abort, out_ready,
    output in_ready, out_valid, s, ovf, busy
  );
endinterface

// File: rtl/reduce_sum_seq.sv
// Serial a + popcount(b): one bit of b per clock, LSB first,
// through a single shared incrementor, with overflow flag.
module reduce_sum_seq #(
  parameter int A_size = 8,
  parameter int B_size = 8
) (
  input logic clk,
  input logic rst_n,
  reduce_sum_seq_if.slave bus
);
  localparam int IW = $clog2(B_size + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [A_size-1:0] acc;
  logic [B_size-1:0] shreg;
  logic [IW-1:0]     idx;
  logic              ovf_q;
  logic              take;
  logic              last;

  assign bus.in_ready  = (state == IDLE) && !bus.abort && rst_n;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.s         = acc;
  assign bus.ovf       = ovf_q;

  assign take = bus.in_valid && bus.in_ready;
  assign last = (idx == IW'(B_size - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: abort wins over completion and out_ready
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take) state_nx = RUN;
      RUN: begin
        if (bus.abort)  state_nx = IDLE;
        else if (last)  state_nx = DONE;
      end
      DONE: begin
        if (bus.abort)          state_nx = IDLE;
        else if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // accumulator, bit shifter, index and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      shreg <= '0;
      idx   <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            acc   <= bus.a;
            shreg <= bus.b;
            idx   <= '0;
            ovf_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            ovf_q <= 1'b0;
          end else begin
            if (shreg[0]) begin
              acc <= acc + A_size'(1);
              if (&acc) ovf_q <= 1'b1;
            end
            shreg <= shreg >> 1;
            idx   <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.abort) ovf_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reduce_sum_seq.sv
// Scoreboard bench for reduce_sum_seq: 8/8 and 4/3 instances.
// Drivers push expectations; monitors pop on result handshake.
module tb_reduce_sum_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reduce_sum_seq_if #(.A_size(8), .B_size(8)) bus8 ();
  reduce_sum_seq_if #(.A_size(4), .B_size(3)) bus4 ();

  reduce_sum_seq #(.A_size(8), .B_size(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
  );
  reduce_sum_seq #(.A_size(4), .B_size(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  typedef struct {
    logic [7:0] s;
    logic       ovf;
    int         n;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor for the 8/8 instance
  int   vc8 = 0;
  logic pv8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus8.out_valid && !pv8) vc8 = cyc;
    pv8 = bus8.out_valid;
    if (bus8.out_valid && bus8.out_ready && !bus8.abort) begin
      if (q8.size() == 0) begin
        chk("unexpected_out8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("s8", 32'(bus8.s), 32'(e.s));
        chk("ovf8", 32'(bus8.ovf), 32'(e.ovf));
        chk("lat8", 32'(vc8 - e.n), 32'd8);
      end
    end
  end

  // monitor for the 4/3 instance
  int   vc4 = 0;
  logic pv4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus4.out_valid && !pv4) vc4 = cyc;
    pv4 = bus4.out_valid;
    if (bus4.out_valid && bus4.out_ready && !bus4.abort) begin
      if (q4.size() == 0) begin
        chk("unexpected_out4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("s4", 32'(bus4.s), 32'(e.s));
        chk("ovf4", 32'(bus4.ovf), 32'(e.ovf));
        chk("lat4", 32'(vc4 - e.n), 32'd3);
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [7:0] es,
                       input logic eo);
    bit ok;
    exp_t e;
    ok = 0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        ok = 1;
        e.s = es;
        e.ovf = eo;
        e.n = cyc + 1;
        if (push) q8.push_back(e);
      end
    end
    if (!ok) chk("accept_timeout8", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [2:0] b,
                       input logic [3:0] es, input logic eo);
    bit ok;
    exp_t e;
    ok = 0;
    @(posedge clk); #1;
    bus4.in_valid = 1'b1;
    bus4.a = a;
    bus4.b = b;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (bus4.in_ready) begin
        ok = 1;
        e.s = {4'h0, es};
        e.ovf = eo;
        e.n = cyc + 1;
        q4.push_back(e);
      end
    end
    if (!ok) chk("accept_timeout4", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait_v8();
    bit ok;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus8.out_valid) ok = 1;
    end
    if (!ok) chk("valid_timeout8", 32'd0, 32'd1);
  endtask

  task automatic wait_v4();
    bit ok;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus4.out_valid) ok = 1;
    end
    if (!ok) chk("valid_timeout4", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] s0;
    logic       o0;
    bit         seen;
    rst_n = 1'b0;
    bus8.in_valid = 0; bus8.a = 0; bus8.b = 0;
    bus8.abort = 0; bus8.out_ready = 1;
    bus4.in_valid = 0; bus4.a = 0; bus4.b = 0;
    bus4.abort = 0; bus4.out_ready = 1;

    #3;
    chk("rst_s", 32'(bus8.s), 32'd0);
    chk("rst_ovf", 32'(bus8.ovf), 32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    #19 rst_n = 1'b1;

    // basic: 5 + popcount(1011_0010) = 9
    send8(8'h05, 8'b1011_0010, 1, 8'h09, 1'b0);
    wait_v8();
    @(negedge clk);
    chk("t1_valid_1cyc", 32'(bus8.out_valid), 32'd0);
    chk("t1_in_ready", 32'(bus8.in_ready), 32'd1);

    // wrap, then ovf cleared on next accept
    send8(8'hFE, 8'hFF, 1, 8'h06, 1'b1);
    wait_v8();
    send8(8'h00, 8'h03, 1, 8'h02, 1'b0);
    wait_v8();

    // b = 0 still takes full latency
    send8(8'hAA, 8'h00, 1, 8'hAA, 1'b0);
    wait_v8();

    // backpressure with an ignored in_valid pulse
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    send8(8'h3C, 8'h0F, 1, 8'h40, 1'b0);
    wait_v8();
    s0 = bus8.s;
    o0 = bus8.ovf;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus8.in_valid = (i == 1);
      bus8.a = 8'h11;
      bus8.b = 8'hFF;
      @(negedge clk);
      chk("bp_s", 32'(bus8.s), 32'(s0));
      chk("bp_ovf", 32'(bus8.ovf), 32'(o0));
      chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
      chk("bp_valid", 32'(bus8.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", 32'(bus8.busy), 32'd0);
    chk("bp_idle_in_ready", 32'(bus8.in_ready), 32'd1);

    // abort on the 3rd RUN edge
    send8(8'h00, 8'hFF, 0, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    bus8.abort = 1'b1;
    @(posedge clk); #1;
    bus8.abort = 1'b0;
    @(negedge clk);
    chk("ab_run_busy", 32'(bus8.busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.out_valid) seen = 1;
    end
    chk("ab_run_no_out", 32'(seen), 32'd0);

    // abort together with out_ready in DONE
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    send8(8'hFF, 8'h01, 0, 8'h00, 1'b0);
    wait_v8();
    chk("ab_done_ovf_pre", 32'(bus8.ovf), 32'd1);
    @(posedge clk); #1;
    bus8.abort = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.abort = 1'b0;
    @(negedge clk);
    chk("ab_done_valid", 32'(bus8.out_valid), 32'd0);
    chk("ab_done_busy", 32'(bus8.busy), 32'd0);
    chk("ab_done_ovf", 32'(bus8.ovf), 32'd0);

    // asynchronous reset mid-RUN
    send8(8'h33, 8'hFF, 0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_s", 32'(bus8.s), 32'd0);
    chk("ar_ovf", 32'(bus8.ovf), 32'd0);
    chk("ar_valid", 32'(bus8.out_valid), 32'd0);
    chk("ar_busy", 32'(bus8.busy), 32'd0);
    chk("ar_in_ready", 32'(bus8.in_ready), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    send8(8'h01, 8'h0F, 1, 8'h05, 1'b0);
    wait_v8();

    // narrow instance: F + 2 wraps
    send4(4'hF, 3'b101, 4'h1, 1'b1);
    wait_v4();

    @(negedge clk);
    @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
